// File: rtl/stream_idx_fifo.sv
// Index-tagged stream FIFO: each entry carries a payload plus the network input it came from.
// Define STREAM_IDX_FIFO_IDX_CNT_EN to build per-index occupancy counters (idx_cnt_o); otherwise they read zero.
module stream_idx_fifo #(
    parameter int unsigned NumInp    = 32'd2,
    parameter int unsigned Depth     = 32'd4,
    parameter int unsigned DataWidth = 32'd1,
    parameter type         payload_t = logic [DataWidth-1:0],
    localparam int unsigned IdxWidth = $clog2(NumInp),
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  payload_t                         data_i,
    input  logic [IdxWidth-1:0]              idx_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output payload_t                         data_o,
    output logic [IdxWidth-1:0]              idx_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [CntWidth-1:0]              usage_o,
    output logic [NumInp-1:0][CntWidth-1:0]  idx_cnt_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    payload_t            data_mem [Depth];
    logic [IdxWidth-1:0] idx_mem  [Depth];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] usage_q, usage_d;
    logic                push, pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (usage_q == CntWidth'(Depth));
    assign empty_o = (usage_q == '0);
    assign ready_o = !full_o && !flush_i;
    assign valid_o = !empty_o;
    assign usage_o = usage_q;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign data_o  = data_mem[rd_ptr_q];
    assign idx_o   = idx_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      usage_d = usage_q + 1'b1;
            else if (pop && !push) usage_d = usage_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Storage is deliberately unreset so it can map onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= data_i;
            idx_mem[wr_ptr_q]  <= idx_i;
        end
    end

`ifdef STREAM_IDX_FIFO_IDX_CNT_EN
    for (genvar gi = 0; gi < NumInp; gi++) begin : g_idx_cnt
        logic                inc, dec;
        logic [CntWidth-1:0] cnt_q, cnt_d;

        always_comb begin
            inc   = push && (idx_i == IdxWidth'(gi));
            dec   = pop  && (idx_o == IdxWidth'(gi));
            cnt_d = cnt_q;
            if (flush_i)          cnt_d = '0;
            else if (inc && !dec) cnt_d = cnt_q + 1'b1;
            else if (dec && !inc) cnt_d = cnt_q - 1'b1;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign idx_cnt_o[gi] = cnt_q;
    end

    logic [31:0] cnt_sum;
    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < NumInp; i++) cnt_sum += 32'(idx_cnt_o[i]);
    end

    assert property (@(posedge clk_i) disable iff (rst_i) cnt_sum == 32'(usage_q));
`else
    assign idx_cnt_o = '0;
`endif

    assert property (@(posedge clk_i) disable iff (rst_i) valid_i |-> (32'(idx_i) < NumInp));
    assert property (@(posedge clk_i) disable iff (rst_i) (valid_i && !ready_o) |=> valid_i);
    assert property (@(posedge clk_i) disable iff (rst_i) (valid_i && !ready_o) |=> $stable(data_i));

endmodule

// File: tb/tb_stream_idx_fifo.sv
// Directed bench for stream_idx_fifo: a Depth=4/NumInp=4 instance for ordering, full, flush and reset,
// and a Depth=3 instance for pointer wrap under continuous streaming.
module tb_stream_idx_fifo;

`ifdef STREAM_IDX_FIFO_IDX_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Depth 4 instance
    logic            flush4 = 0, vin4 = 0, rdy_in4 = 0;
    logic [7:0]      din4 = '0;
    logic [1:0]      idx_in4 = '0;
    logic            rdy_out4, vout4, full4, empty4;
    logic [7:0]      dout4;
    logic [1:0]      idx_out4;
    logic [2:0]      usage4;
    logic [3:0][2:0] cnt4;

    // Depth 3 instance
    logic            flush3 = 0, vin3 = 0, rdy_in3 = 0;
    logic [7:0]      din3 = '0;
    logic [0:0]      idx_in3 = '0;
    logic            rdy_out3, vout3, full3, empty3;
    logic [7:0]      dout3;
    logic [0:0]      idx_out3;
    logic [1:0]      usage3;
    logic [1:0][1:0] cnt3;

    stream_idx_fifo #(.NumInp(4), .Depth(4), .DataWidth(8)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush4),
        .data_i(din4), .idx_i(idx_in4), .valid_i(vin4), .ready_o(rdy_out4),
        .data_o(dout4), .idx_o(idx_out4), .valid_o(vout4), .ready_i(rdy_in4),
        .usage_o(usage4), .idx_cnt_o(cnt4), .full_o(full4), .empty_o(empty4)
    );

    stream_idx_fifo #(.NumInp(2), .Depth(3), .DataWidth(8)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush3),
        .data_i(din3), .idx_i(idx_in3), .valid_i(vin3), .ready_o(rdy_out3),
        .data_o(dout3), .idx_o(idx_out3), .valid_o(vout3), .ready_i(rdy_in3),
        .usage_o(usage3), .idx_cnt_o(cnt3), .full_o(full3), .empty_o(empty3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_d [4];
    logic [1:0] exp_i [4];

    initial begin
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_i = '{2'd1, 2'd1, 2'd3, 2'd0};

        // reset state
        #1;
        chk("rst_valid", 32'(vout4), 32'd0);
        chk("rst_ready", 32'(rdy_out4), 32'd1);
        chk("rst_empty", 32'(empty4), 32'd1);
        chk("rst_full", 32'(full4), 32'd0);
        chk("rst_usage", 32'(usage4), 32'd0);
        chk("rst_cnt", 32'(cnt4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // fill with idx 1,1,3,0 while downstream stalls
        for (int k = 0; k < 4; k++) begin
            vin4 = 1'b1; din4 = exp_d[k]; idx_in4 = exp_i[k];
            #1;
            if (k == 0) chk("no_fallthrough", 32'(vout4), 32'd0);
            tick();
            if (k == 0) begin
                chk("lat1_valid", 32'(vout4), 32'd1);
                chk("lat1_data", 32'(dout4), 32'hA1);
            end
        end
        vin4 = 1'b0;
        chk("fill_full", 32'(full4), 32'd1);
        chk("fill_ready", 32'(rdy_out4), 32'd0);
        chk("fill_usage", 32'(usage4), 32'd4);
        chk("fill_cnt", 32'(cnt4), CntEn ? 32'h211 : 32'h0);

        tick();
        tick();
        chk("stall_data", 32'(dout4), 32'hA1);
        chk("stall_idx", 32'(idx_out4), 32'd1);

        // drain in order
        rdy_in4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_data%0d", k), 32'(dout4), 32'(exp_d[k]));
            chk($sformatf("drain_idx%0d", k), 32'(idx_out4), 32'(exp_i[k]));
            chk($sformatf("drain_valid%0d", k), 32'(vout4), 32'd1);
            tick();
        end
        rdy_in4 = 1'b0;
        chk("drain_valid_end", 32'(vout4), 32'd0);
        chk("drain_empty", 32'(empty4), 32'd1);
        chk("drain_cnt", 32'(cnt4), 32'd0);

        // full with simultaneous valid_i and ready_i: pop only
        for (int k = 0; k < 4; k++) begin
            vin4 = 1'b1; din4 = 8'h10 + 8'(k); idx_in4 = 2'd2;
            tick();
        end
        din4 = 8'h20; idx_in4 = 2'd3; rdy_in4 = 1'b1;
        #1;
        chk("fullpop_ready", 32'(rdy_out4), 32'd0);
        tick();
        chk("fullpop_usage", 32'(usage4), 32'd3);
        chk("fullpop_head", 32'(dout4), 32'h11);
        rdy_in4 = 1'b0;
        tick();
        vin4 = 1'b0;
        chk("refill_usage", 32'(usage4), 32'd4);
        chk("refill_cnt", 32'(cnt4), CntEn ? 32'h2C0 : 32'h0);

        // flush with two entries held and valid_i high
        rdy_in4 = 1'b1;
        tick();
        tick();
        rdy_in4 = 1'b0;
        chk("preflush_usage", 32'(usage4), 32'd2);
        chk("preflush_head", 32'(dout4), 32'h13);
        flush4 = 1'b1; vin4 = 1'b1; din4 = 8'h30; idx_in4 = 2'd1;
        #1;
        chk("flush_ready", 32'(rdy_out4), 32'd0);
        tick();
        flush4 = 1'b0;
        chk("flush_usage", 32'(usage4), 32'd0);
        chk("flush_valid", 32'(vout4), 32'd0);
        chk("flush_cnt", 32'(cnt4), 32'd0);
        tick();
        vin4 = 1'b0;
        chk("postflush_usage", 32'(usage4), 32'd1);
        chk("postflush_data", 32'(dout4), 32'h30);
        chk("postflush_idx", 32'(idx_out4), 32'd1);
        chk("postflush_cnt", 32'(cnt4), CntEn ? 32'h008 : 32'h0);

        // asynchronous reset mid-burst
        rdy_in4 = 1'b1; vin4 = 1'b1; din4 = 8'h40; idx_in4 = 2'd2;
        tick();
        din4 = 8'h41;
        tick();
        chk("burst_head", 32'(dout4), 32'h41);
        chk("burst_usage", 32'(usage4), 32'd1);
        din4 = 8'h42;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(vout4), 32'd0);
        chk("arst_usage", 32'(usage4), 32'd0);
        chk("arst_empty", 32'(empty4), 32'd1);
        chk("arst_ready", 32'(rdy_out4), 32'd1);
        chk("arst_cnt", 32'(cnt4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_in4 = 1'b0; vin4 = 1'b1; din4 = 8'h50; idx_in4 = 2'd3;
        tick();
        vin4 = 1'b0;
        chk("resume_valid", 32'(vout4), 32'd1);
        chk("resume_data", 32'(dout4), 32'h50);
        chk("resume_usage", 32'(usage4), 32'd1);

        // Depth 3: continuous streaming across pointer wrap
        vin3 = 1'b1; din3 = 8'd0; idx_in3 = 1'b0;
        tick();
        rdy_in3 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din3 = 8'(k + 1); idx_in3 = 1'((k + 1) % 2);
            chk($sformatf("wrap_data%0d", k), 32'(dout3), 32'(k));
            chk($sformatf("wrap_usage%0d", k), 32'(usage3), 32'd1);
            tick();
        end
        vin3 = 1'b0; rdy_in3 = 1'b0;
        chk("wrap_final_data", 32'(dout3), 32'd10);
        chk("wrap_final_idx", 32'(idx_out3), 32'd0);
        chk("wrap_final_usage", 32'(usage3), 32'd1);
        chk("wrap_final_cnt", 32'(cnt3), CntEn ? 32'h1 : 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
